if_id_reg: RTL and testbench

- Pipeline register between the fetch stage and decode.
- Latches the fetched instruction word (Order) and its PC+4 (FAOut) each cycle.
- Holds these values when a load-use hazard is detected, and drives the Hazard stall input back into fetch.
- Flushes to a bubble when fetch is redirected by branch (Flag) or jump (Jump).
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/if_id_reg.sv | 97 +++++++++
 tb/tb_if_id_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg - IF/ID pipeline register with load-use stall and redirect flush
//
// Captures the fetched instruction word and its PC+4 each cycle. When the
// load in ID/EX writes a register that the instruction now in ID reads, the
// register holds its contents, and Hazard asks fetch to hold PC and ID/EX to
// insert a bubble. A branch (Flag) or jump (Jump) redirect discards the
// wrong-path fetch by loading a bubble. Two saturating counters record how
// many stall cycles and how many redirect cycles have occurred.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   Order       instruction word from fetch
//   FAOut       PC+4 of that instruction
//   Flag        branch taken (fetch redirect)
//   Jump        jump taken (fetch redirect)
//   ex_memread  instruction in ID/EX is a load
//   ex_rt       destination register of that load
//   cnt_clr     synchronous clear of both event counters
//   ID_Order    registered instruction for decode
//   ID_PC4      registered PC+4 for decode
//   ID_Valid    ID_Order holds a real instruction rather than a bubble
//   Hazard      stall request to fetch and bubble request to ID/EX
//   stall_cnt   number of cycles with Hazard asserted (saturating)
//   flush_cnt   number of redirect cycles (saturating)
// ---------------------------------------------------------------------------
module if_id_reg #(
  parameter logic [31:0] NOP   = 32'h0000_0000,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Order,
  input  logic [31:0]      FAOut,
  input  logic             Flag,
  input  logic             Jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             cnt_clr,
  output logic [31:0]      ID_Order,
  output logic [31:0]      ID_PC4,
  output logic             ID_Valid,
  output logic             Hazard,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       redirect;
  logic       raw_hz;

  assign id_rs    = ID_Order[25:21];
  assign id_rt    = ID_Order[20:16];
  assign redirect = Flag | Jump;

  // A load into r0 never produces a value worth waiting for.
  assign raw_hz = ID_Valid & ex_memread & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));

  // Redirect wins: stalling fetch during a redirect would drop the target.
  assign Hazard = raw_hz & ~redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ID_Order <= NOP;
      ID_PC4   <= 32'd0;
      ID_Valid <= 1'b0;
    end else if (redirect) begin
      ID_Order <= NOP;
      ID_PC4   <= 32'd0;
      ID_Valid <= 1'b0;
    end else if (!Hazard) begin
      ID_Order <= Order;
      ID_PC4   <= FAOut;
      ID_Valid <= 1'b1;
    end
  end

  // Clear takes priority over a same-cycle event, which is then not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (Hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_reg - self-checking bench for if_id_reg
//
// A small reference model predicts the register contents and counters for
// each driven cycle; the prediction is queued when the inputs are applied and
// compared against the DUT once the clock edge has passed. Hazard is checked
// combinationally before each edge. Counters use a 4-bit width so saturation
// is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_if_id_reg;

  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  typedef struct {
    logic [31:0] order;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      Order = '0;
  logic [31:0]      FAOut = '0;
  logic             Flag = 1'b0;
  logic             Jump = 1'b0;
  logic             ex_memread = 1'b0;
  logic [4:0]       ex_rt = '0;
  logic             cnt_clr = 1'b0;
  logic [31:0]      ID_Order;
  logic [31:0]      ID_PC4;
  logic             ID_Valid;
  logic             Hazard;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks   = 0;
  int failures = 0;

  exp_t sb_q[$];

  // reference model state
  logic [31:0] m_order;
  logic [31:0] m_pc4;
  logic        m_valid;
  int          m_stall;
  int          m_flush;
  int          sat_max;

  if_id_reg #(.NOP(NOP), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .Order      (Order),
    .FAOut      (FAOut),
    .Flag       (Flag),
    .Jump       (Jump),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .cnt_clr    (cnt_clr),
    .ID_Order   (ID_Order),
    .ID_PC4     (ID_PC4),
    .ID_Valid   (ID_Valid),
    .Hazard     (Hazard),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_order = NOP;
    m_pc4   = 32'd0;
    m_valid = 1'b0;
    m_stall = 0;
    m_flush = 0;
    sb_q.delete();
  endtask

  // Applies one cycle of stimulus (caller is just after a rising edge),
  // predicts the outcome, then compares after the edge.
  task automatic cycle(input logic [31:0] ord, input logic [31:0] pc4,
                       input logic flg, input logic jmp,
                       input logic mrd, input logic [4:0] rt,
                       input logic clr);
    logic redir;
    logic hz;
    exp_t e;
    exp_t got;
    Order = ord; FAOut = pc4; Flag = flg; Jump = jmp;
    ex_memread = mrd; ex_rt = rt; cnt_clr = clr;
    #2;
    redir = flg | jmp;
    hz = m_valid && mrd && (rt != 5'd0) &&
         ((rt == m_order[25:21]) || (rt == m_order[20:16])) && !redir;
    chk("hazard", {31'd0, Hazard}, {31'd0, hz});
    if (redir) begin
      m_order = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
    end else if (!hz) begin
      m_order = ord; m_pc4 = pc4; m_valid = 1'b1;
    end
    if (clr) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (hz && m_stall < sat_max) m_stall++;
      if (redir && m_flush < sat_max) m_flush++;
    end
    e.order = m_order; e.pc4 = m_pc4; e.valid = m_valid;
    e.stall = m_stall; e.flush = m_flush;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    chk("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
    if (sb_q.size() != 0) begin
      got = sb_q.pop_front();
      chk("id_order",  ID_Order, got.order);
      chk("id_pc4",    ID_PC4, got.pc4);
      chk("id_valid",  {31'd0, ID_Valid}, {31'd0, got.valid});
      chk("stall_cnt", {{(32-CNT_W){1'b0}}, stall_cnt}, got.stall);
      chk("flush_cnt", {{(32-CNT_W){1'b0}}, flush_cnt}, got.flush);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_order"}, ID_Order, NOP);
    chk({tag, "_pc4"},   ID_PC4, 32'd0);
    chk({tag, "_valid"}, {31'd0, ID_Valid}, 32'd0);
    chk({tag, "_hazard"}, {31'd0, Hazard}, 32'd0);
    chk({tag, "_stall"}, {{(32-CNT_W){1'b0}}, stall_cnt}, 32'd0);
    chk({tag, "_flush"}, {{(32-CNT_W){1'b0}}, flush_cnt}, 32'd0);
  endtask

  // rs=3, rt=1
  localparam logic [31:0] I_RS3 = 32'h0061_0000;

  initial begin
    sat_max = (1 << CNT_W) - 1;
    model_reset();

    // reset state, with a load pending on the ID/EX side
    ex_memread = 1'b1; ex_rt = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    ex_memread = 1'b0; ex_rt = 5'd0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // first instruction loads after one edge
    cycle(32'h2002_0005, 32'd4, 0, 0, 0, 5'd0, 0);
    chk("first_order", ID_Order, 32'h2002_0005);
    chk("first_pc4",   ID_PC4, 32'd4);

    // load-use stall on rs, then release
    cycle(I_RS3, 32'd8, 0, 0, 0, 5'd0, 0);
    cycle(32'h1111_1111, 32'd12, 0, 0, 1, 5'd3, 0);
    chk("stall_hold_order", ID_Order, I_RS3);
    chk("stall_cnt_one", {{(32-CNT_W){1'b0}}, stall_cnt}, 32'd1);
    cycle(32'h1111_1111, 32'd12, 0, 0, 0, 5'd3, 0);
    chk("release_order", ID_Order, 32'h1111_1111);

    // 0x11111111 decodes to rs=8, rt=17: match on rt, then r0, then no load
    cycle(32'h2222_2222, 32'd16, 0, 0, 1, 5'd17, 0);
    cycle(32'h2222_2222, 32'd16, 0, 0, 0, 5'd17, 0);
    cycle(I_RS3, 32'd20, 0, 0, 1, 5'd0, 0);
    cycle(32'h3333_3333, 32'd24, 0, 0, 0, 5'd3, 0);

    // hazard condition with a branch in the same cycle: redirect wins
    cycle(I_RS3, 32'd28, 0, 0, 0, 5'd0, 0);
    cycle(32'h4444_4444, 32'd32, 1, 0, 1, 5'd3, 0);
    chk("flag_bubble_valid", {31'd0, ID_Valid}, 32'd0);
    chk("flag_flush_cnt", {{(32-CNT_W){1'b0}}, flush_cnt}, 32'd1);
    chk("flag_stall_cnt", {{(32-CNT_W){1'b0}}, stall_cnt}, 32'd2);

    // three back-to-back jumps, then a valid load
    for (int i = 0; i < 3; i++)
      cycle(32'h5555_0000 + i, 32'd36 + 4*i, 0, 1, 0, 5'd0, 0);
    chk("jump_flush_cnt", {{(32-CNT_W){1'b0}}, flush_cnt}, 32'd4);
    cycle(32'h6666_6666, 32'd48, 0, 0, 0, 5'd0, 0);
    chk("jump_release_valid", {31'd0, ID_Valid}, 32'd1);

    // saturation: hold a stall for 20 cycles
    cycle(I_RS3, 32'd52, 0, 0, 0, 5'd0, 0);
    for (int i = 0; i < 20; i++)
      cycle(32'h7777_7777, 32'd56, 0, 0, 1, 5'd1, 0);
    chk("stall_saturated", {{(32-CNT_W){1'b0}}, stall_cnt}, 32'd15);
    cycle(32'h7777_7777, 32'd56, 0, 0, 1, 5'd1, 1);
    chk("clr_with_hazard", {{(32-CNT_W){1'b0}}, stall_cnt}, 32'd0);

    // randomized mix of loads, redirects and clears
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ord;
      logic [4:0]  rt;
      ord = $urandom;
      rt  = ($urandom_range(0, 1) == 1) ? m_order[25:21] : 5'($urandom_range(0, 31));
      cycle(ord, 32'd100 + 4*i, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 2) != 0), rt, ($urandom_range(0, 19) == 0));
    end

    // asynchronous reset in the middle of a stall
    cycle(I_RS3, 32'd300, 0, 0, 0, 5'd0, 0);
    cycle(32'h8888_8888, 32'd304, 0, 0, 1, 5'd3, 0);
    Flag = 1'b0; Jump = 1'b0; ex_memread = 1'b1; ex_rt = 5'd3; cnt_clr = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(32'h2002_0005, 32'd4, 0, 0, 0, 5'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
